// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: arbitrates the register file's single write port between
// the main pipeline writeback (A, high priority) and the multi-cycle unit
// writeback (B, low priority). Granted writes appear on rf_* one cycle later.
// B starvation is capped: after STARVE_LIMIT consecutive A grants while B
// waits, B is force-granted for one cycle.
// Optional build macro: WB_R0_DISCARD_EN (drop writes to register 0 after
// acknowledging them).
module rf_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_wr,
  input  logic [31:0] a_wd,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_wr,
  input  logic [31:0] b_wd,
  output logic        b_ready,
  output logic        rf_write,
  output logic [4:0]  rf_wr,
  output logic [31:0] rf_wd,
  output logic        starved
);

  typedef enum logic {
    PRI_A   = 1'b0,
    FORCE_B = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state, next_state;
  logic [CNT_W-1:0] starve_cnt, cnt_next;
  logic             a_grant, b_grant;
  logic [4:0]       sel_wr;
  logic [31:0]      sel_wd;
  logic             write_next;

  // State and starvation counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= PRI_A;
      starve_cnt <= '0;
    end else begin
      state      <= next_state;
      starve_cnt <= cnt_next;
    end
  end

  // Ready generation, next state and starvation counter update
  always_comb begin
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    starved    = 1'b0;
    next_state = state;
    cnt_next   = starve_cnt;
    case (state)
      PRI_A: begin
        if (a_valid)      a_ready = 1'b1;
        else if (b_valid) b_ready = 1'b1;
        if (a_valid && b_valid) begin
          // B lost to A this cycle; saturate rather than wrap
          cnt_next = (starve_cnt == '1) ? starve_cnt : starve_cnt + 1'b1;
          if (cnt_next >= LIMIT) next_state = FORCE_B;
        end else begin
          cnt_next = '0;
        end
      end
      FORCE_B: begin
        // One forced B slot; if B has dropped valid nothing transfers
        b_ready    = 1'b1;
        starved    = 1'b1;
        next_state = PRI_A;
        cnt_next   = '0;
      end
      default: begin
        next_state = PRI_A;
        cnt_next   = '0;
      end
    endcase
    if (rst) begin
      a_ready = 1'b0;
      b_ready = 1'b0;
    end
  end

  // Select the granted source's write for registering
  always_comb begin
    a_grant    = a_valid && a_ready;
    b_grant    = b_valid && b_ready;
    sel_wr     = a_grant ? a_wr : b_wr;
    sel_wd     = a_grant ? a_wd : b_wd;
`ifdef WB_R0_DISCARD_EN
    write_next = (a_grant || b_grant) && (sel_wr != 5'd0);
`else
    write_next = a_grant || b_grant;
`endif
  end

  // Registered write port; address and data hold when nothing is granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_write <= 1'b0;
      rf_wr    <= '0;
      rf_wd    <= '0;
    end else begin
      rf_write <= write_next;
      if (a_grant || b_grant) begin
        rf_wr <= sel_wr;
        rf_wd <= sel_wd;
      end
    end
  end

endmodule
